// File: rtl/uart_tx.sv
// Purpose: FIFO-fed UART transmitter; pops one word per frame and shifts it out LSB first (optional even parity with UART_TX_PARITY_EN).
// Latency: FETCH and LOAD take one cycle each before the start bit; frame is (DATA_WIDTH+2)*CLKS_PER_BIT cycles, +CLKS_PER_BIT with parity.
// Backpressure: pops only when f_empty is low in IDLE or on the last stop cycle; FIFO state is ignored while a frame is in flight.
module uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  f_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  rd_en,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_done
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         bit_cnt, cnt_nxt;
    logic [IW-1:0]         bit_idx, idx_nxt;
    logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
    logic                  tx_nxt, rd_en_nxt, done_nxt;
`ifdef UART_TX_PARITY_EN
    logic                  par_bit, par_nxt;
`endif

    // Next-state and datapath: the bit timer counts down and reloads on every bit entry.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = bit_cnt;
        idx_nxt   = bit_idx;
        shreg_nxt = shreg;
`ifdef UART_TX_PARITY_EN
        par_nxt   = par_bit;
`endif
        case (state)
            IDLE: begin
                if (!f_empty) state_nxt = FETCH;
            end
            FETCH: begin
                state_nxt = LOAD;
            end
            LOAD: begin
                // FIFO read data is valid the cycle after the pop request.
                shreg_nxt = fifo_dout;
`ifdef UART_TX_PARITY_EN
                par_nxt   = ^fifo_dout;
`endif
                cnt_nxt   = BIT_LAST;
                state_nxt = START;
            end
            START: begin
                if (bit_cnt == '0) begin
                    cnt_nxt   = BIT_LAST;
                    idx_nxt   = '0;
                    state_nxt = DATA;
                end else begin
                    cnt_nxt = bit_cnt - CW'(1);
                end
            end
            DATA: begin
                if (bit_cnt == '0) begin
                    cnt_nxt = BIT_LAST;
                    if (bit_idx == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end else begin
                        idx_nxt   = bit_idx + IW'(1);
                        shreg_nxt = shreg >> 1;
                    end
                end else begin
                    cnt_nxt = bit_cnt - CW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_cnt == '0) begin
                    cnt_nxt   = BIT_LAST;
                    state_nxt = STOP;
                end else begin
                    cnt_nxt = bit_cnt - CW'(1);
                end
            end
`endif
            STOP: begin
                // Chaining straight into FETCH keeps the inter-frame gap at two cycles.
                if (bit_cnt == '0) begin
                    state_nxt = f_empty ? IDLE : FETCH;
                end else begin
                    cnt_nxt = bit_cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output decode from the next state so registered outputs line up with the state register.
    always_comb begin
        tx_nxt    = 1'b1;
        rd_en_nxt = (state_nxt == FETCH);
        done_nxt  = (state_nxt == STOP) && (cnt_nxt == '0);
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shreg_nxt[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_nxt = par_nxt;
`endif
            default: tx_nxt = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counters and shift register; reset drops any byte in flight.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
`ifdef UART_TX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            bit_cnt <= cnt_nxt;
            bit_idx <= idx_nxt;
            shreg   <= shreg_nxt;
`ifdef UART_TX_PARITY_EN
            par_bit <= par_nxt;
`endif
        end
    end

    // Registered outputs: no combinational path from inputs.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tx      <= 1'b1;
            rd_en   <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            tx      <= tx_nxt;
            rd_en   <= rd_en_nxt;
            tx_done <= done_nxt;
        end
    end

    assign tx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx.sv
// Purpose: self-checking bench for uart_tx with a non-show-ahead FIFO model and an expected-byte queue.
// Latency: frames are decoded from the serial line sampled on falling clock edges.
// Backpressure: the FIFO model pops one entry per rd_en cycle; bytes are queued at arbitrary points mid-frame.
module tb_uart_tx;

    localparam int CPB = 4;
    localparam int DW  = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = DW + 3;
`else
    localparam int NBITS = DW + 2;
`endif
    localparam int FRAME_CYC = NBITS * CPB;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          f_empty;
    logic [DW-1:0] fifo_dout;
    logic          rd_en;
    logic          tx;
    logic          tx_busy;
    logic          tx_done;

    int n_checks = 0;
    int n_fail   = 0;
    int rd_cnt   = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];

    uart_tx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .f_empty   (f_empty),
        .fifo_dout (fifo_dout),
        .rd_en     (rd_en),
        .tx        (tx),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;

    // FIFO model: read data appears the cycle after the pop request.
    always @(negedge clk) begin
        if (rd_en === 1'b1) begin
            rd_cnt++;
            if (fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
            f_empty = (fifo_q.size() == 0);
        end
    end

    task automatic push_byte(input logic [DW-1:0] v);
        fifo_q.push_back(v);
        exp_q.push_back(v);
        f_empty = 1'b0;
    endtask

    // Waits for a start bit, then samples one full frame; bv[k] is the first sample of bit slot k.
    task automatic capture(input int push_at, input logic [DW-1:0] push_val,
                           output logic [15:0] bv, output bit bits_ok, output int done_cnt,
                           output int done_pos, output int gap, output int idle_in_gap,
                           output int busy_low, output bit timed_out);
        bv = '0; bits_ok = 1'b1; done_cnt = 0; done_pos = -1;
        gap = 0; idle_in_gap = 0; busy_low = 0; timed_out = 1'b0;
        @(negedge clk);
        while (tx !== 1'b0) begin
            if (tx_busy !== 1'b1) idle_in_gap++;
            gap++;
            if (gap > 300) begin
                timed_out = 1'b1;
                return;
            end
            @(negedge clk);
        end
        for (int c = 0; c < FRAME_CYC; c++) begin
            if (c > 0) @(negedge clk);
            if (c % CPB == 0) bv[c / CPB] = tx;
            else if (tx !== bv[c / CPB]) bits_ok = 1'b0;
            if (tx_done === 1'b1) begin
                done_cnt++;
                done_pos = c;
            end
            if (tx_busy !== 1'b1) busy_low++;
            if (c == push_at) push_byte(push_val);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b1;
        f_empty = 1'b1;
        fifo_dout = '0;
        #1 n_rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
        n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
        n_checks++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", tx_done); end
        n_rst = 1'b1;
    endtask

    task automatic test_idle();
        int bad_rd, bad_tx, bad_busy;
        bad_rd = 0; bad_tx = 0; bad_busy = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rd_en !== 1'b0) bad_rd++;
            if (tx !== 1'b1) bad_tx++;
            if (tx_busy !== 1'b0) bad_busy++;
        end
        n_checks++; if (bad_rd != 0) begin n_fail++; $display("FAIL idle_rd_en: %0d cycles high, want 0", bad_rd); end
        n_checks++; if (bad_tx != 0) begin n_fail++; $display("FAIL idle_tx: %0d cycles low, want 0", bad_tx); end
        n_checks++; if (bad_busy != 0) begin n_fail++; $display("FAIL idle_busy: %0d cycles high, want 0", bad_busy); end
    endtask

    task automatic test_single();
        logic [15:0] bv; bit ok, to; int dc, dp, gap, idl, bl, r0;
        logic [DW-1:0] exp;
        r0 = rd_cnt;
        @(negedge clk);
        push_byte(8'hA5);
        capture(-1, '0, bv, ok, dc, dp, gap, idl, bl, to);
        n_checks++; if (to) begin n_fail++; $display("FAIL single_start: no start bit within 300 cycles"); end
        exp = '0;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        n_checks++; if (bv[DW:1] !== exp) begin n_fail++; $display("FAIL single_data: got %h want %h", bv[DW:1], exp); end
        n_checks++; if (bv[0] !== 1'b0) begin n_fail++; $display("FAIL single_start_bit: got %b want 0", bv[0]); end
        n_checks++; if (bv[NBITS-1] !== 1'b1) begin n_fail++; $display("FAIL single_stop_bit: got %b want 1", bv[NBITS-1]); end
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_bit_width: a bit was not held %0d cycles", CPB); end
        n_checks++; if (dc != 1) begin n_fail++; $display("FAIL single_done_count: got %0d want 1", dc); end
        n_checks++; if (dp != FRAME_CYC - 1) begin n_fail++; $display("FAIL single_done_pos: got %0d want %0d", dp, FRAME_CYC - 1); end
        n_checks++; if (bl != 0) begin n_fail++; $display("FAIL single_busy: low %0d cycles in frame, want 0", bl); end
        repeat (4) @(negedge clk);
        n_checks++; if (rd_cnt - r0 != 1) begin n_fail++; $display("FAIL single_rd_pulses: got %0d want 1", rd_cnt - r0); end
        n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy: got %b want 0", tx_busy); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] bv; bit ok, to; int dc, dp, gap, idl, bl, r0;
        logic [DW-1:0] exp;
        r0 = rd_cnt;
        @(negedge clk);
        push_byte(8'h00);
        push_byte(8'hFF);
        push_byte(8'h55);
        for (int i = 0; i < 3; i++) begin
            capture(-1, '0, bv, ok, dc, dp, gap, idl, bl, to);
            n_checks++; if (to) begin n_fail++; $display("FAIL b2b_start[%0d]: no start bit", i); end
            exp = '0;
            if (exp_q.size() > 0) exp = exp_q.pop_front();
            n_checks++; if (bv[DW:1] !== exp) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", i, bv[DW:1], exp); end
            n_checks++; if (ok !== 1'b1 || bv[NBITS-1] !== 1'b1) begin n_fail++; $display("FAIL b2b_framing[%0d]: width_ok %b stop %b want 1 1", i, ok, bv[NBITS-1]); end
            n_checks++; if (dc != 1) begin n_fail++; $display("FAIL b2b_done[%0d]: got %0d want 1", i, dc); end
            if (i > 0) begin
                n_checks++; if (gap != 2) begin n_fail++; $display("FAIL b2b_gap[%0d]: got %0d want 2", i, gap); end
            end
        end
        repeat (3) @(negedge clk);
        n_checks++; if (rd_cnt - r0 != 3) begin n_fail++; $display("FAIL b2b_rd_pulses: got %0d want 3", rd_cnt - r0); end
        n_checks++; if (tx_busy !== 1'b0 || tx !== 1'b1) begin n_fail++; $display("FAIL b2b_end_idle: busy %b tx %b want 0 1", tx_busy, tx); end
    endtask

    // Bytes arrive during DATA of one frame and during STOP of the next.
    task automatic test_fill_in_frame();
        logic [15:0] bv; bit ok, to; int dc, dp, gap, idl, bl;
        logic [DW-1:0] exp;
        logic [DW-1:0] vals [3];
        vals[0] = 8'h3C; vals[1] = 8'hC3; vals[2] = 8'h81;
        @(negedge clk);
        push_byte(vals[0]);
        for (int i = 0; i < 3; i++) begin
            if (i == 0) capture(10, vals[1], bv, ok, dc, dp, gap, idl, bl, to);
            else if (i == 1) capture(FRAME_CYC - 3, vals[2], bv, ok, dc, dp, gap, idl, bl, to);
            else capture(-1, '0, bv, ok, dc, dp, gap, idl, bl, to);
            n_checks++; if (to) begin n_fail++; $display("FAIL fill_start[%0d]: no start bit", i); end
            exp = '0;
            if (exp_q.size() > 0) exp = exp_q.pop_front();
            n_checks++; if (bv[DW:1] !== exp || ok !== 1'b1) begin n_fail++; $display("FAIL fill_data[%0d]: got %h width_ok %b want %h 1", i, bv[DW:1], ok, exp); end
            if (i > 0) begin
                n_checks++; if (gap != 2) begin n_fail++; $display("FAIL fill_gap[%0d]: got %0d want 2", i, gap); end
                n_checks++; if (idl != 0) begin n_fail++; $display("FAIL fill_no_idle[%0d]: %0d idle cycles want 0", i, idl); end
            end
        end
        repeat (3) @(negedge clk);
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [15:0] bv; bit ok, to; int dc, dp, gap, idl, bl;
        logic [DW-1:0] exp;
        logic [DW-1:0] vals [2];
        vals[0] = 8'h07; vals[1] = 8'h03;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            push_byte(vals[i]);
            capture(-1, '0, bv, ok, dc, dp, gap, idl, bl, to);
            exp = '0;
            if (exp_q.size() > 0) exp = exp_q.pop_front();
            n_checks++; if (to || bv[DW:1] !== exp) begin n_fail++; $display("FAIL parity_data[%0d]: got %h timeout %b want %h", i, bv[DW:1], to, exp); end
            n_checks++; if (bv[DW+1] !== ^exp) begin n_fail++; $display("FAIL parity_bit[%0d]: got %b want %b", i, bv[DW+1], ^exp); end
            n_checks++; if (dp != 43 || ok !== 1'b1) begin n_fail++; $display("FAIL parity_frame_len[%0d]: done at %0d width_ok %b want 43 1", i, dp, ok); end
            repeat (4) @(negedge clk);
        end
    endtask
`endif

    task automatic test_reset_mid_frame();
        int w, bad_tx, bad_done, bad_rd, bad_busy;
        w = 0; bad_tx = 0; bad_done = 0; bad_rd = 0; bad_busy = 0;
        @(negedge clk);
        push_byte(8'hA5);
        @(negedge clk);
        while (tx !== 1'b0 && w < 300) begin
            w++;
            @(negedge clk);
        end
        n_checks++; if (w >= 300) begin n_fail++; $display("FAIL rst_mid_start: no start bit within 300 cycles"); end
        // Second cycle of data bit 3 (bit 3 of 0xA5 is 0).
        repeat (17) @(negedge clk);
        n_checks++; if (tx !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pre_tx: got %b want 0", tx); end
        n_rst = 1'b0;
        #1;
        n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rst_mid_tx: got %b want 1", tx); end
        n_checks++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_done: got %b want 0", tx_done); end
        n_checks++; if (tx_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", tx_busy); end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) bad_tx++;
            if (tx_done !== 1'b0) bad_done++;
            if (rd_en !== 1'b0) bad_rd++;
            if (tx_busy !== 1'b0) bad_busy++;
        end
        n_checks++; if (bad_tx != 0) begin n_fail++; $display("FAIL rst_after_tx: %0d low cycles want 0", bad_tx); end
        n_checks++; if (bad_done != 0) begin n_fail++; $display("FAIL rst_after_done: %0d pulses want 0", bad_done); end
        n_checks++; if (bad_rd != 0 || bad_busy != 0) begin n_fail++; $display("FAIL rst_after_activity: rd %0d busy %0d want 0 0", bad_rd, bad_busy); end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_back_to_back();
        test_fill_in_frame();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, bits per frame payload.
REQ-003 SHALL have port clk  input  1  single system clock, all state rising-edge triggered.
REQ-004 SHALL have port n_rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port f_empty  input  1  TX FIFO empty flag.
REQ-006 SHALL have port fifo_dout  input  DATA_WIDTH  TX FIFO read data.
REQ-007 SHALL have port rd_en  output  1  FIFO pop request, one-cycle pulse per byte.
REQ-008 SHALL have port tx  output  1  serial line, idle high.
REQ-009 SHALL have port tx_busy  output  1  high in every state except IDLE.
REQ-010 SHALL have port tx_done  output  1  one-cycle pulse at frame end.

Function
REQ-011 SHALL implement states IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
REQ-012 SHALL leave IDLE for FETCH on the first edge where f_empty=0; SHALL otherwise stay in IDLE.
REQ-013 SHALL drive rd_en=1 only in FETCH, which lasts exactly one cycle; next state is LOAD.
REQ-014 SHALL capture fifo_dout into a shift register at the end of LOAD; next state is START.
REQ-015 SHALL drive tx=1 in IDLE, FETCH and LOAD.
REQ-016 SHALL drive tx=0 for exactly CLKS_PER_BIT cycles in START.
REQ-017 SHALL send DATA_WIDTH data bits LSB first in DATA, each held for exactly CLKS_PER_BIT cycles.
REQ-018 SHALL count bit time with a down-counter reloaded to CLKS_PER_BIT-1 on every bit entry; the bit ends when the counter reaches 0.
REQ-019 SHALL count data bits with a counter of width clog2(DATA_WIDTH); DATA ends after bit index DATA_WIDTH-1.
REQ-020 SHALL drive tx=1 for exactly CLKS_PER_BIT cycles in STOP.
REQ-021 SHALL pulse tx_done=1 on the last cycle of STOP.
REQ-022 SHALL go from the last STOP cycle directly to FETCH if f_empty=0, else to IDLE, so back-to-back frames have 2 extra high cycles between the stop bit and the next start bit.
REQ-023 SHALL ignore f_empty and fifo_dout outside IDLE, LOAD and the last STOP cycle; a FIFO fill mid-frame SHALL NOT disturb the frame in flight.
REQ-024 SHALL register tx, rd_en and tx_done (no combinational path from inputs to outputs).

Reset
REQ-025 SHALL on n_rst=0 immediately force state=IDLE, tx=1, rd_en=0, tx_busy=0, tx_done=0, and clear the counters and shift register.
REQ-026 SHALL discard a byte whose frame is interrupted by reset; it SHALL NOT be re-fetched.
REQ-027 SHALL leave IDLE no earlier than the first rising edge after n_rst deasserts.

Configuration
REQ-028 SHALL compile in the PARITY state when macro UART_TX_PARITY_EN is defined.
REQ-029 With UART_TX_PARITY_EN defined, SHALL send one even-parity bit (XOR of the data bits) for CLKS_PER_BIT cycles between DATA and STOP; frame = (DATA_WIDTH+3)*CLKS_PER_BIT cycles.
REQ-030 Without UART_TX_PARITY_EN, SHALL go directly from DATA to STOP; frame = (DATA_WIDTH+2)*CLKS_PER_BIT cycles.

Verification (CLKS_PER_BIT=4, DATA_WIDTH=8)
REQ-031 SHALL check: f_empty low with 0xA5 at the FIFO -> one rd_en pulse; tx = 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles; tx_done pulses once.
REQ-032 SHALL check: 3 bytes 0x00, 0xFF, 0x55 queued -> exactly 3 rd_en pulses; 2 high cycles between each stop bit and the next start bit; after the last frame, IDLE and tx_busy=0.
REQ-033 SHALL check: f_empty held high for 100 cycles -> rd_en=0, tx=1, tx_busy=0 throughout.
REQ-034 SHALL check: n_rst asserted in cycle 2 of data bit 3 -> tx=1 the same cycle, no tx_done; after release with f_empty=1, the line stays idle.
REQ-035 SHALL check: UART_TX_PARITY_EN defined, byte 0x07 -> parity bit 1; byte 0x03 -> parity bit 0; frame 44 cycles.
REQ-036 SHALL check: f_empty falls during STOP of the previous frame -> FETCH follows the last STOP cycle with no IDLE cycle.
